// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and helpers for the 4x4 keypad matrix scanner.
//   ROWS, COLS, KEYS  - matrix geometry (KEYS = ROWS*COLS frame bits)
//   kp_state_t        - key-event FSM states
//   onehot_info_t     - result of onehot16_to_idx (index + single-bit flag)
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KEYS = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LOCK  = 2'd2
  } kp_state_t;

  typedef struct packed {
    logic       single;
    logic [3:0] idx;
  } onehot_info_t;

  // idx is only meaningful when single is set; for multi-bit vectors it
  // reports the highest set bit, which callers ignore.
  function automatic onehot_info_t onehot16_to_idx(input logic [KEYS-1:0] vec);
    onehot_info_t info;
    int unsigned  cnt;
    info.idx    = 4'd0;
    info.single = 1'b0;
    cnt         = 0;
    for (int i = 0; i < KEYS; i++) begin
      if (vec[i]) begin
        info.idx = 4'(i);
        cnt++;
      end
    end
    info.single = (cnt == 1);
    return info;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_debouncer.sv
// keypad_frame_debouncer
// Accepts a 16-key frame only after DEBOUNCE_SCANS consecutive identical
// frames. Evaluated once per frame_stb; commit is a one-cycle pulse and cf
// carries the frame that was evaluated alongside it.
//   clk, rst_n  - clock, async active-low reset
//   frame_new   - completed scan frame (1 = key pressed)
//   frame_stb   - one-cycle pulse, frame_new is valid
//   commit      - frame accepted as stable (every stable frame, not just edges)
//   cf          - committed frame
module keypad_frame_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [KEYS-1:0] frame_new,
  input  logic            frame_stb,
  output logic            commit,
  output logic [KEYS-1:0] cf
);

  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_SCANS);

  logic [KEYS-1:0] frame_prev;
  logic [3:0]      match_cnt;
  logic [3:0]      match_nxt;
  logic            same;

  assign same = (frame_new == frame_prev);

  always_comb begin
    match_nxt = match_cnt;
    if (same) begin
      if (match_cnt < DB_MAX) match_nxt = match_cnt + 4'd1;
    end else begin
      match_nxt = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_prev <= '0;
      match_cnt  <= 4'd0;
      commit     <= 1'b0;
      cf         <= '0;
    end else begin
      commit <= 1'b0;
      if (frame_stb) begin
        match_cnt <= match_nxt;
        if (!same) frame_prev <= frame_new;
        commit <= (match_nxt >= DB_MAX);
        cf     <= frame_new;
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
// Scans a 4x4 passive key matrix one column at a time, debounces whole
// frames and emits one key code per clean single-key press.
//   clk, rst_n  - clock, async active-low reset
//   key_row     - row sense pins, active low, asynchronous to clk
//   key_col     - column drive, active low, one-cold
//   key_code    - last reported key (row*4 + col), held between presses
//   key_valid   - one-cycle strobe on an accepted new press
//   key_held    - FSM is not in IDLE
//
// state | meaning
// IDLE  | no key committed, waiting for a stable single key
// PRESS | single key reported, waiting for a stable release
// LOCK  | rollover/ghost seen, waiting for a stable release, no events
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] key_row,
  output logic [COLS-1:0] key_col,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic            key_held
);

  localparam int              CNT_W   = $clog2(SCAN_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV);

  logic [ROWS-1:0]  row_meta;
  logic [ROWS-1:0]  row_sync;
  logic [ROWS-1:0]  row_s;
  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       col_sel;
  logic             sample_edge;
  logic [KEYS-1:0]  frame_acc;
  logic [KEYS-1:0]  frame_nxt;
  logic [KEYS-1:0]  frame_new;
  logic             frame_stb;
  logic             commit;
  logic [KEYS-1:0]  cf;
  onehot_info_t     cf_info;
  kp_state_t        state;

  assign row_s       = ~row_sync;
  // Last cycle of the column dwell: the driven column has settled through
  // the synchroniser by now, so this is where the rows are sampled.
  assign sample_edge = (scan_cnt == CNT_MAX);

  always_comb begin
    frame_nxt = frame_acc;
    for (int r = 0; r < ROWS; r++) begin
      frame_nxt[r*COLS + int'(col_sel)] = row_s[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta  <= '0;
      row_sync  <= '0;
      scan_cnt  <= '0;
      col_sel   <= 2'd0;
      key_col   <= 4'b1110;
      frame_acc <= '0;
      frame_new <= '0;
      frame_stb <= 1'b0;
    end else begin
      row_meta  <= key_row;
      row_sync  <= row_meta;
      frame_stb <= 1'b0;
      if (sample_edge) begin
        scan_cnt  <= '0;
        col_sel   <= col_sel + 2'd1;
        // Rotating one-cold register keeps the pin drive glitch-free.
        key_col   <= {key_col[COLS-2:0], key_col[COLS-1]};
        frame_acc <= frame_nxt;
        if (col_sel == 2'(COLS - 1)) begin
          frame_new <= frame_nxt;
          frame_stb <= 1'b1;
        end
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  keypad_frame_debouncer #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debouncer (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame_new(frame_new),
    .frame_stb(frame_stb),
    .commit   (commit),
    .cf       (cf)
  );

  assign cf_info = onehot16_to_idx(cf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (commit) begin
        case (state)
          IDLE: begin
            if (cf_info.single) begin
              key_code  <= cf_info.idx;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= PRESS;
            end else if (cf != '0) begin
              key_held <= 1'b1;
              state    <= LOCK;
            end
          end
          PRESS: begin
            if (cf == '0) begin
              key_held <= 1'b0;
              state    <= IDLE;
            end else if (!(cf_info.single && cf_info.idx == key_code)) begin
              state <= LOCK;
            end
          end
          LOCK: begin
            if (cf == '0) begin
              key_held <= 1'b0;
              state    <= IDLE;
            end
          end
          default: begin
            key_held <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner
// Self-checking bench: models the passive matrix from the driven columns,
// applies a table of press/release steps and a few timed corner sequences.
// Expected key codes go into a queue when a press is driven and are popped
// when key_valid strobes.
module tb_keypad_matrix_scanner;

  localparam int SCAN_DIV = 3;
  localparam int DEB      = 3;
  localparam int FRAME    = 4 * (SCAN_DIV + 1);

  typedef struct {
    logic [15:0] mask;
    int          frames;
    int          push;
    logic        exp_held;
    logic [3:0]  exp_code;
  } vec_t;

  localparam int NV = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;
  logic [3:0]  exp_col;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobe_cyc = -1;
  int exp_code_m;
  int c0;
  int n;
  int exp_q[$];
  vec_t vec[NV];

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Passive matrix: row r pulled low when a pressed key sits on a driven column.
  always_comb begin
    key_row = '1;
    for (int r = 0; r < 4; r++) key_row[r] = ~|(pressed[r*4 +: 4] & ~key_col);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      total++;
      strobe_cyc = cyc;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected: got strobe code=%0d at cyc=%0d, required no strobe", key_code, cyc);
      end else begin
        exp_code_m = exp_q.pop_front();
        if (int'(key_code) != exp_code_m) begin
          bad++;
          $display("FAIL strobe_code: got %0d, required %0d", key_code, exp_code_m);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic align();
    int k;
    k = 0;
    while ((cyc % FRAME) != 0 && k < 4 * FRAME) begin
      @(negedge clk);
      k++;
    end
    if (k >= 4 * FRAME) begin
      total++;
      bad++;
      $display("FAIL frame_align: got cyc=%0d, required a frame boundary", cyc);
    end
  endtask

  task automatic wait_strobe(input string name);
    n = 0;
    while (exp_q.size() != 0 && n < 20 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{16'h0000, 4,  -1, 1'b0, 4'd0};
    vec[1]  = '{16'h0200, 10,  9, 1'b1, 4'd9};
    vec[2]  = '{16'h0000, 4,  -1, 1'b0, 4'd9};
    vec[3]  = '{16'h0010, 5,   4, 1'b1, 4'd4};
    vec[4]  = '{16'h8010, 5,  -1, 1'b1, 4'd4};
    vec[5]  = '{16'h8000, 5,  -1, 1'b1, 4'd4};
    vec[6]  = '{16'h0000, 5,  -1, 1'b0, 4'd4};
    vec[7]  = '{16'h8000, 5,  15, 1'b1, 4'd15};
    vec[8]  = '{16'h0000, 5,  -1, 1'b0, 4'd15};
    vec[9]  = '{16'h0401, 5,  -1, 1'b1, 4'd15};
    vec[10] = '{16'h0000, 5,  -1, 1'b0, 4'd15};
    vec[11] = '{16'h0020, 5,   5, 1'b1, 4'd5};
    vec[12] = '{16'h0040, 5,  -1, 1'b1, 4'd5};
    vec[13] = '{16'h0000, 5,  -1, 1'b0, 4'd5};

    // Reset state and column stepping
    rst_n   = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    check("reset_key_col", key_col, 4'b1110);
    check("reset_key_code", key_code, 0);
    check("reset_key_valid", key_valid, 0);
    check("reset_key_held", key_held, 0);
    rst_n = 1'b1;
    check("col_step0", key_col, 4'b1110);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      check($sformatf("col_step%0d", i), key_col, exp_col);
    end

    // Table-driven press/release steps
    for (int v = 0; v < NV; v++) begin
      align();
      pressed = vec[v].mask;
      if (vec[v].push >= 0) exp_q.push_back(vec[v].push);
      repeat (vec[v].frames * FRAME) @(negedge clk);
      check($sformatf("vec%0d_key_held", v), key_held, vec[v].exp_held);
      check($sformatf("vec%0d_key_code", v), key_code, vec[v].exp_code);
      check($sformatf("vec%0d_strobe_count", v), exp_q.size(), 0);
      exp_q.delete();
    end

    // Bounce on key (0,3): toggles every 5 cycles, then stable from the
    // frame starting 96 cycles in (ends at c0+112).
    align();
    c0 = cyc;
    for (int i = 0; i < 19; i++) begin
      pressed = (i % 2 == 1) ? 16'h0008 : 16'h0000;
      repeat (5) @(negedge clk);
    end
    check("bounce_no_held", key_held, 0);
    pressed = 16'h0008;
    exp_q.push_back(3);
    wait_strobe("bounce_strobe_seen");
    check("bounce_latency", strobe_cyc - c0, 7 * FRAME + (DEB - 1) * FRAME + 2);
    check("bounce_key_code", key_code, 3);
    pressed = '0;
    repeat (5 * FRAME) @(negedge clk);
    check("bounce_release_held", key_held, 0);

    // Reset while a key is held
    align();
    pressed = 16'h4000;
    exp_q.push_back(14);
    repeat (5 * FRAME) @(negedge clk);
    check("rst_pre_key_code", key_code, 14);
    check("rst_pre_key_held", key_held, 1);
    check("rst_pre_strobe_count", exp_q.size(), 0);
    exp_q.delete();
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_key_col", key_col, 4'b1110);
    check("rst_mid_key_code", key_code, 0);
    check("rst_mid_key_held", key_held, 0);
    check("rst_mid_key_valid", key_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(14);
    wait_strobe("rst_post_strobe_seen");
    check("rst_post_latency", strobe_cyc, DEB * FRAME + 2);
    check("rst_post_key_held", key_held, 1);
    pressed = '0;
    repeat (5 * FRAME) @(negedge clk);
    check("rst_post_release_held", key_held, 0);
    check("rst_post_key_code", key_code, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
